// File: rtl/primogen_arbiter.sv
// Round-robin arbiter sharing one primogen prime generator between N_REQ requesters.
// Define PRIMOGEN_ARB_TIMEOUT_EN to abort a stuck generator after TIMEOUT cycles.
module primogen_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [WIDTH-1:0] res,
  output logic             err,
  output logic             busy,
  output logic             gen_go,
  output logic             gen_rst,
  input  logic             gen_ready,
  input  logic             gen_error,
  input  logic [WIDTH-1:0] gen_res
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_DROP, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    winner_q, winner_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [PW-1:0]    pick;
  logic             pick_vld;
  logic [PW:0]      scan;

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  // First requester at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(N_REQ)) scan = scan - (PW+1)'(N_REQ);
      if (!pick_vld && req[scan[PW-1:0]]) begin
        pick     = scan[PW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    res_d    = res_q;
    err_d    = err_q;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          winner_d = pick;
          state_d  = S_GO;
        end
      end
      S_GO: begin
        state_d = S_DROP;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_DROP: begin
        if (!gen_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gen_ready) begin
          res_d   = gen_res;
          err_d   = gen_error;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    // A real result arriving on the last cycle wins over the timeout.
    if ((state_q == S_DROP || state_q == S_WAIT) && state_d != S_DONE) begin
      if (cnt_q == TMO_LAST) begin
        state_d = S_DONE;
        res_d   = '0;
        err_d   = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      res_q    <= res_d;
      err_q    <= err_d;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign ack[gi] = (state_q == S_DONE) && (winner_q == PW'(gi));
  end

  assign res    = res_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);
  assign gen_go = (state_q == S_GO);

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
  // tmo_q is high during the DONE cycle of an aborted grant, restarting primogen.
  assign gen_rst = rst | tmo_q;
`else
  assign gen_rst = rst;
`endif

endmodule
